// File: rtl/bus_host_master_if.sv
// Host-command, response, bus and interrupt signals of bus_host_master.
// The master modport is the DUT view; the slave modport is its environment.
interface bus_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        M0_req;
  logic        M0_wr;
  logic [7:0]  M0_address;
  logic [31:0] M0_dout;
  logic        M0_grant;
  logic [31:0] M_din;
  logic        F_interrupt;
  logic        D_interrupt;
  logic [1:0]  irq_status;
  logic [1:0]  irq_clr;
  logic [15:0] txn_count;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, M0_grant, M_din,
    input  F_interrupt, D_interrupt, irq_clr,
    output cmd_ready, rsp_valid, rsp_rdata, M0_req, M0_wr, M0_address, M0_dout,
    output irq_status, txn_count
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, M0_grant, M_din,
    output F_interrupt, D_interrupt, irq_clr,
    input  cmd_ready, rsp_valid, rsp_rdata, M0_req, M0_wr, M0_address, M0_dout,
    input  irq_status, txn_count
  );
endinterface

// File: rtl/bus_host_master.sv
// Host bus master: command FIFO feeding a req/grant bus FSM with read-response capture.
// Macro HOST_IRQ_LATCH_EN selects latched edge-detected interrupt status (default: pass-through).
module bus_host_master #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               reset_n,
  bus_host_master_if.master bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StRdata} state_e;
  state_e r_state, w_state_d;

  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr, w_load_ptr;
  logic [CntW-1:0] r_count;
  logic            r_fifo_wr   [FIFO_DEPTH];
  logic [7:0]      r_fifo_addr [FIFO_DEPTH];
  logic [31:0]     r_fifo_data [FIFO_DEPTH];
  logic            w_full, w_empty, w_push, w_pop, w_load;

  logic        r_req, r_wr, w_req_d, w_wr_d;
  logic [7:0]  r_addr, w_addr_d;
  logic [31:0] r_dout, w_dout_d;
  logic        r_rsp_valid, w_rsp_valid_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic [15:0] r_txn_count;

  assign w_full  = (r_count == CntW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.cmd_valid & ~w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wr[r_wr_ptr]   <= bus.cmd_wr;
      r_fifo_addr[r_wr_ptr] <= bus.cmd_addr;
      r_fifo_data[r_wr_ptr] <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  // The head stays queued until granted; a completing write may chain straight into the next entry.
  always_comb begin
    w_state_d     = r_state;
    w_req_d       = r_req;
    w_wr_d        = r_wr;
    w_addr_d      = r_addr;
    w_dout_d      = r_dout;
    w_rsp_valid_d = 1'b0;
    w_rdata_d     = r_rdata;
    w_pop         = 1'b0;
    w_load        = 1'b0;
    w_load_ptr    = r_rd_ptr;
    unique case (r_state)
      StIdle: begin
        w_req_d = 1'b0;
        w_wr_d  = 1'b0;
        if (!w_empty) begin
          w_load    = 1'b1;
          w_state_d = StReq;
        end
      end
      StReq: begin
        if (bus.M0_grant) begin
          w_pop = 1'b1;
          if (r_wr) begin
            if (r_count > CntW'(1)) begin
              w_load     = 1'b1;
              w_load_ptr = r_rd_ptr + PtrW'(1);
            end else begin
              w_state_d = StIdle;
              w_req_d   = 1'b0;
              w_wr_d    = 1'b0;
            end
          end else begin
            w_state_d = StRdata;
            w_wr_d    = 1'b0;
          end
        end
      end
      StRdata: begin
        w_rsp_valid_d = 1'b1;
        w_rdata_d     = bus.M_din;
        if (!w_empty) begin
          w_load    = 1'b1;
          w_state_d = StReq;
        end else begin
          w_state_d = StIdle;
          w_req_d   = 1'b0;
          w_wr_d    = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_load) begin
      w_req_d  = 1'b1;
      w_wr_d   = r_fifo_wr[w_load_ptr];
      w_addr_d = r_fifo_addr[w_load_ptr];
      w_dout_d = r_fifo_data[w_load_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_dout      <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_txn_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_req       <= w_req_d;
      r_wr        <= w_wr_d;
      r_addr      <= w_addr_d;
      r_dout      <= w_dout_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rdata     <= w_rdata_d;
      if (w_pop) r_txn_count <= r_txn_count + 16'd1;
    end
  end

  assign bus.cmd_ready  = ~w_full;
  assign bus.M0_req     = r_req;
  assign bus.M0_wr      = r_wr;
  assign bus.M0_address = r_addr;
  assign bus.M0_dout    = r_dout;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rdata;
  assign bus.txn_count  = r_txn_count;

`ifdef HOST_IRQ_LATCH_EN
  logic       r_f_prev, r_d_prev;
  logic [1:0] r_irq, w_irq_set;

  assign w_irq_set = {bus.D_interrupt & ~r_d_prev, bus.F_interrupt & ~r_f_prev};

  // Set takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f_prev <= 1'b0;
      r_d_prev <= 1'b0;
      r_irq    <= '0;
    end else begin
      r_f_prev <= bus.F_interrupt;
      r_d_prev <= bus.D_interrupt;
      r_irq    <= (r_irq & ~bus.irq_clr) | w_irq_set;
    end
  end

  assign bus.irq_status = r_irq;
`else
  logic [1:0] w_unused_irq_clr;
  assign w_unused_irq_clr = bus.irq_clr;
  assign bus.irq_status   = {bus.D_interrupt, bus.F_interrupt};
`endif
endmodule

// File: tb/tb_bus_host_master.sv
// Scoreboard bench for bus_host_master: directed stimulus pushes expected bus transfers and
// read responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_bus_host_master;
  logic clk;
  logic reset_n;

  bus_host_master_if bus ();

  bus_host_master #(.FIFO_DEPTH(4)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [31:0] exp_rsp[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] rdata);
    int n;
    bus_exp_t e;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: cmd_ready got 0, expected 1 within 50 cycles");
    end else begin
      e.wr   = wr;
      e.addr = a;
      e.data = d;
      exp_bus.push_back(e);
      if (!wr) exp_rsp.push_back(rdata);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Monitor: a granted request is a transfer; the cycle after a read transfer is RDATA.
  initial begin
    bus_exp_t e;
    logic     skip;
    skip = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        skip = 1'b0;
      end else begin
        if (skip) begin
          skip = 1'b0;
        end else if (bus.M0_req && bus.M0_grant) begin
          if (exp_bus.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_xfer: got addr 0x%02h, expected no transfer", bus.M0_address);
          end else begin
            e = exp_bus.pop_front();
            check("xfer_wr", {31'd0, bus.M0_wr}, {31'd0, e.wr});
            check("xfer_addr", {24'd0, bus.M0_address}, {24'd0, e.addr});
            if (e.wr) check("xfer_dout", bus.M0_dout, e.data);
            else skip = 1'b1;
          end
        end
        if (bus.rsp_valid) begin
          if (exp_rsp.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got 0x%08h, expected no response", bus.rsp_rdata);
          end else begin
            check("rsp_rdata", bus.rsp_rdata, exp_rsp.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_wr      = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_wdata   = '0;
    bus.M0_grant    = 1'b0;
    bus.M_din       = '0;
    bus.F_interrupt = 1'b0;
    bus.D_interrupt = 1'b0;
    bus.irq_clr     = '0;

    // Reset state
    tick();
    tick();
    check("rst_req", {31'd0, bus.M0_req}, 32'd0);
    check("rst_wr", {31'd0, bus.M0_wr}, 32'd0);
    check("rst_addr", {24'd0, bus.M0_address}, 32'd0);
    check("rst_dout", bus.M0_dout, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_txn", {16'd0, bus.txn_count}, 32'd0);
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_irq", {30'd0, bus.irq_status}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Write A with grant held high
    bus.M0_grant = 1'b1;
    push_cmd(1'b1, 8'h20, 32'h0000_0005, 32'd0);
    check("wa_req_idle", {31'd0, bus.M0_req}, 32'd0);
    tick();
    check("wa_bus", {22'd0, bus.M0_req, bus.M0_wr, bus.M0_address}, {22'd0, 2'b11, 8'h20});
    check("wa_dout", bus.M0_dout, 32'h5);
    tick();
    check("wa_req_drop", {30'd0, bus.M0_req, bus.M0_wr}, 32'd0);
    check("wa_txn", {16'd0, bus.txn_count}, 32'd1);

    // Read with grant withheld five cycles, then lost during RDATA
    bus.M0_grant = 1'b0;
    bus.M_din    = 32'hDEAD_BEEF;
    push_cmd(1'b0, 8'h40, 32'h1234_5678, 32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("rd_hold", {22'd0, bus.M0_req, bus.M0_wr, bus.M0_address}, {22'd0, 2'b10, 8'h40});
      tick();
    end
    bus.M0_grant = 1'b1;
    tick();
    check("rd_rdata_cycle", {30'd0, bus.M0_req, bus.rsp_valid}, {30'd0, 2'b10});
    check("rd_rdata_wr", {31'd0, bus.M0_wr}, 32'd0);
    bus.M0_grant = 1'b0;
    tick();
    check("rd_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("rd_rdata_val", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("rd_req_drop", {31'd0, bus.M0_req}, 32'd0);
    tick();
    check("rd_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);
    check("rd_rdata_hold", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("rd_txn", {16'd0, bus.txn_count}, 32'd2);

    // FIFO full, then four back-to-back writes
    push_cmd(1'b1, 8'h01, 32'hA000_0001, 32'd0);
    push_cmd(1'b1, 8'h02, 32'hA000_0002, 32'd0);
    push_cmd(1'b1, 8'h03, 32'hA000_0003, 32'd0);
    push_cmd(1'b1, 8'h04, 32'hA000_0004, 32'd0);
    check("full_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("full_head", {23'd0, bus.M0_req, bus.M0_address}, {23'd0, 1'b1, 8'h01});
    bus.M0_grant = 1'b1;
    tick();
    check("b2b_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("b2b_2", {23'd0, bus.M0_req, bus.M0_address}, {23'd0, 1'b1, 8'h02});
    tick();
    check("b2b_3", {23'd0, bus.M0_req, bus.M0_address}, {23'd0, 1'b1, 8'h03});
    tick();
    check("b2b_4", {23'd0, bus.M0_req, bus.M0_address}, {23'd0, 1'b1, 8'h04});
    tick();
    check("b2b_done", {31'd0, bus.M0_req}, 32'd0);
    check("b2b_txn", {16'd0, bus.txn_count}, 32'd6);
    bus.M0_grant = 1'b0;

    // Interrupts
`ifdef HOST_IRQ_LATCH_EN
    bus.F_interrupt = 1'b1;
    tick();
    check("irq_f_set", {30'd0, bus.irq_status}, 32'b01);
    bus.irq_clr     = 2'b01;
    bus.D_interrupt = 1'b1;
    tick();
    check("irq_d_set_f_clr", {30'd0, bus.irq_status}, 32'b10);
    bus.irq_clr     = 2'b00;
    bus.F_interrupt = 1'b0;
    tick();
    bus.F_interrupt = 1'b1;
    bus.irq_clr     = 2'b01;
    tick();
    check("irq_set_wins", {30'd0, bus.irq_status}, 32'b11);
    bus.irq_clr = 2'b11;
    tick();
    check("irq_clr_all", {30'd0, bus.irq_status}, 32'b00);
    bus.irq_clr = 2'b00;
`else
    bus.F_interrupt = 1'b1;
    #1;
    check("irq_pass_f", {30'd0, bus.irq_status}, 32'b01);
    bus.irq_clr     = 2'b11;
    bus.D_interrupt = 1'b1;
    tick();
    check("irq_pass_clr_ignored", {30'd0, bus.irq_status}, 32'b11);
    bus.F_interrupt = 1'b0;
    #1;
    check("irq_pass_d", {30'd0, bus.irq_status}, 32'b10);
    bus.irq_clr = 2'b00;
`endif
    bus.F_interrupt = 1'b0;
    bus.D_interrupt = 1'b0;
    tick();

    // Reset in the middle of a pending read
    push_cmd(1'b0, 8'h55, 32'd0, 32'h0BAD_0BAD);
    push_cmd(1'b1, 8'h66, 32'h6666_6666, 32'd0);
    check("rr_req", {23'd0, bus.M0_req, bus.M0_address}, {23'd0, 1'b1, 8'h55});
    #2;
    reset_n = 1'b0;
    #1;
    check("rr_req_async", {31'd0, bus.M0_req}, 32'd0);
    check("rr_txn_async", {16'd0, bus.txn_count}, 32'd0);
    exp_bus.delete();
    exp_rsp.delete();
    tick();
    reset_n      = 1'b1;
    bus.M0_grant = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("rr_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rr_req_idle", {31'd0, bus.M0_req}, 32'd0);
    check("rr_txn", {16'd0, bus.txn_count}, 32'd0);
    check("rr_rdata", bus.rsp_rdata, 32'd0);

    check("left_bus_exp", exp_bus.size(), 32'd0);
    check("left_rsp_exp", exp_rsp.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
